// File: rtl/vrf_pkg.sv
// Shared vtype field layout, encodings, geometry helpers and write-FSM state type for the
// vector register file.
package vrf_pkg;

  localparam int unsigned VLMUL_LSB = 0;
  localparam int unsigned VLMUL_W   = 3;
  localparam int unsigned VSEW_LSB  = 3;
  localparam int unsigned VSEW_W    = 3;
  localparam int unsigned VRSV_LSB  = 6;
  localparam int unsigned VRSV_W    = 2;

  localparam logic [2:0] VSEW_8    = 3'd0;
  localparam logic [2:0] VSEW_16   = 3'd1;
  localparam logic [2:0] VSEW_32   = 3'd2;
  localparam logic [2:0] VSEW_64   = 3'd3;
  localparam logic [2:0] VLMUL_1   = 3'd0;
  localparam logic [2:0] VLMUL_2   = 3'd1;
  localparam logic [2:0] VLMUL_4   = 3'd2;
  localparam logic [2:0] VLMUL_8   = 3'd3;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  function automatic int unsigned sew_bytes(input logic [2:0] vsew);
    return 32'd1 << vsew;
  endfunction

  function automatic int unsigned lmul_regs(input logic [2:0] vlmul);
    return 32'd1 << vlmul;
  endfunction

  function automatic int unsigned vlmax(input logic [2:0] vsew, input logic [2:0] vlmul,
                                        input int unsigned vlen);
    return (vlen >> (32'd3 + 32'(vsew))) << vlmul;
  endfunction

endpackage

// File: rtl/vreg_file_grp_if.sv
// Bundle of read ports, vsetvl channel, write-beat channel and CSR status for vreg_file_grp.
interface vreg_file_grp_if #(
  parameter int unsigned VLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned VLW  = $clog2(VLEN) + 1
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*VLEN-1:0] rd;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [VLW-1:0]      avl_in;
  logic [7:0]          vtype_in;
  logic                w_valid;
  logic                w_ready;
  logic [AW-1:0]       w_addr;
  logic [VLEN-1:0]     w_data;
  logic                w_vm;
  logic                w_whole;
  logic [VLW-1:0]      vl;
  logic [7:0]          vtype;
  logic                vill;
  logic [VLW-1:0]      avl_reg;
  logic                busy;
  logic                w_err;

  modport master (
    output ra, cfg_valid, avl_in, vtype_in, w_valid, w_addr, w_data, w_vm, w_whole,
    input  rd, cfg_ready, w_ready, vl, vtype, vill, avl_reg, busy, w_err
  );

  modport slave (
    input  ra, cfg_valid, avl_in, vtype_in, w_valid, w_addr, w_data, w_vm, w_whole,
    output rd, cfg_ready, w_ready, vl, vtype, vill, avl_reg, busy, w_err
  );

endinterface

// File: rtl/vrf_elem_mask.sv
// Byte-enable generator for one beat of a group write: element e = beat*EPR + i is enabled
// when it lies below vl and is either unmasked or selected by the v0 snapshot.
module vrf_elem_mask #(
  parameter int unsigned VLEN = 64,
  parameter int unsigned VLW  = $clog2(VLEN) + 1
) (
  input  logic [VLW-1:0]    vl,
  input  logic [2:0]        vsew,
  input  logic [2:0]        beat,
  input  logic              vm,
  input  logic [VLEN-1:0]   v0_snap,
  output logic [VLEN/8-1:0] byte_en
);
  localparam int unsigned NB   = VLEN / 8;
  localparam int unsigned LOGV = $clog2(VLEN);

  logic [31:0] epr;
  logic [31:0] elem;

  always_comb begin
    byte_en = '0;
    epr     = NB >> vsew;
    elem    = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      elem       = 32'(beat) * epr + (b >> vsew);
      // Out-of-range indices only occur when elem >= vl, where the compare already fails.
      byte_en[b] = (elem < 32'(vl)) && (vm || v0_snap[elem[LOGV-1:0]]);
    end
  end

endmodule

// File: rtl/vreg_file_grp.sv
// Vector register file with vl/vtype CSRs and LMUL group burst writes.
// Optional VRF_BYPASS_EN: reads of the register being written return the merged new value.
module vreg_file_grp
  import vrf_pkg::*;
#(
  parameter int unsigned VLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned VLW  = $clog2(VLEN) + 1
) (
  input logic           clk,
  input logic           rst,
  vreg_file_grp_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned NB = VLEN / 8;

  logic [VLEN-1:0] data_q [NREG];
  state_e          state_q, state_d;
  logic [VLW-1:0]  vl_q, avl_q, vl_new;
  logic [7:0]      vtype_q;
  logic            vill_q, cfg_ill, cfg_fire;
  logic [AW-1:0]   base_q, base_d, wr_addr;
  logic [2:0]      beat_q, beat_d, m_beat;
  logic            vm_q, vm_d, m_vm;
  logic [VLEN-1:0] snap_q, snap_d, m_snap, merged;
  logic            err_q, err_d, wr_en, wr_whole, misalign;
  logic [NB-1:0]   mask_be, wr_be;
  int unsigned     lmul, vmax;

  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign bus.cfg_ready = (state_q == ST_IDLE);
  assign bus.w_ready   = 1'b1;
  assign bus.vl        = vl_q;
  assign bus.vtype     = vtype_q;
  assign bus.vill      = vill_q;
  assign bus.avl_reg   = avl_q;
  assign bus.busy      = (state_q == ST_BURST);
  assign bus.w_err     = err_q;

  always_comb begin
    cfg_ill = (bus.vtype_in[VSEW_LSB+:VSEW_W] > VSEW_64) ||
              (bus.vtype_in[VLMUL_LSB+:VLMUL_W] > VLMUL_8) ||
              (bus.vtype_in[VRSV_LSB+:VRSV_W] != '0);
    vmax    = vlmax(bus.vtype_in[VSEW_LSB+:VSEW_W], bus.vtype_in[VLMUL_LSB+:VLMUL_W], VLEN);
    if (cfg_ill)                    vl_new = '0;
    else if (32'(bus.avl_in) < vmax) vl_new = bus.avl_in;
    else                            vl_new = VLW'(vmax);
  end

  always_comb begin
    lmul     = lmul_regs(vtype_q[VLMUL_LSB+:VLMUL_W]);
    misalign = (32'(bus.w_addr) & (lmul - 32'd1)) != '0;
    state_d  = state_q;
    base_d   = base_q;
    beat_d   = beat_q;
    vm_d     = vm_q;
    snap_d   = snap_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    wr_whole = 1'b0;
    wr_addr  = bus.w_addr;
    m_beat   = '0;
    m_vm     = bus.w_vm;
    m_snap   = data_q[0];
    case (state_q)
      ST_IDLE: begin
        if (bus.w_valid) begin
          if (bus.w_whole) begin
            wr_en    = 1'b1;
            wr_whole = 1'b1;
          end else if (misalign) begin
            err_d = 1'b1;
          end else if (!vill_q) begin
            wr_en = 1'b1;
            if (lmul > 32'd1) begin
              state_d = ST_BURST;
              base_d  = bus.w_addr;
              beat_d  = 3'd1;
              vm_d    = bus.w_vm;
              snap_d  = data_q[0];
            end
          end
        end
      end
      ST_BURST: begin
        m_beat  = beat_q;
        m_vm    = vm_q;
        m_snap  = snap_q;
        wr_addr = base_q + AW'(beat_q);
        if (bus.w_valid) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 3'd1;
          if (32'(beat_q) == lmul - 32'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  vrf_elem_mask #(
    .VLEN (VLEN),
    .VLW  (VLW)
  ) u_elem_mask (
    .vl      (vl_q),
    .vsew    (vtype_q[VSEW_LSB+:VSEW_W]),
    .beat    (m_beat),
    .vm      (m_vm),
    .v0_snap (m_snap),
    .byte_en (mask_be)
  );

  assign wr_be = wr_whole ? '1 : mask_be;

  always_comb begin
    merged = data_q[wr_addr];
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_be[b]) merged[b*8+:8] = bus.w_data[b*8+:8];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.ra[p*AW+:AW];
`ifdef VRF_BYPASS_EN
    assign bus.rd[p*VLEN+:VLEN] = (wr_en && (a == wr_addr)) ? merged : data_q[a];
`else
    assign bus.rd[p*VLEN+:VLEN] = data_q[a];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      vl_q    <= '0;
      avl_q   <= '0;
      vtype_q <= '0;
      vill_q  <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      vm_q    <= 1'b0;
      snap_q  <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      vm_q    <= vm_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
      if (wr_en) data_q[wr_addr] <= merged;
      if (cfg_fire) begin
        vl_q    <= vl_new;
        vtype_q <= bus.vtype_in;
        vill_q  <= cfg_ill;
        avl_q   <= bus.avl_in;
      end
    end
  end

endmodule

// File: tb/tb_vreg_file_grp.sv
// Directed bench for vreg_file_grp: CSR updates, masked/tail writes, group bursts, reset abort.
module tb_vreg_file_grp;
  localparam int unsigned VLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned VLW  = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vreg_file_grp_if #(.VLEN(VLEN), .NREG(NREG), .NRD(NRD), .VLW(VLW)) bus ();

  vreg_file_grp #(.VLEN(VLEN), .NREG(NREG), .NRD(NRD), .VLW(VLW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string tag, input int r, input logic [63:0] exp);
    int p;
    p = r & 1;
    bus.ra[p*5+:5] = 5'(r);
    #1;
    chk(tag, bus.rd[p*64+:64], exp);
  endtask

  task automatic vsetvl(input logic [6:0] avl, input logic [7:0] vt);
    bus.cfg_valid = 1'b1;
    bus.avl_in    = avl;
    bus.vtype_in  = vt;
    cycle();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wbeat(input logic [4:0] addr, input logic [63:0] d, input logic vm,
                       input logic whole);
    bus.w_valid = 1'b1;
    bus.w_addr  = addr;
    bus.w_data  = d;
    bus.w_vm    = vm;
    bus.w_whole = whole;
    cycle();
    bus.w_valid = 1'b0;
    bus.w_whole = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ra        = '0;
    bus.cfg_valid = 1'b0;
    bus.avl_in    = '0;
    bus.vtype_in  = '0;
    bus.w_valid   = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.w_vm      = 1'b1;
    bus.w_whole   = 1'b0;
    rst           = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;

    // 1: reset state
    chk("rst_vl", 64'(bus.vl), 64'd0);
    chk("rst_vtype", 64'(bus.vtype), 64'd0);
    chk("rst_vill", 64'(bus.vill), 64'd0);
    chk("rst_avl", 64'(bus.avl_reg), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_werr", 64'(bus.w_err), 64'd0);
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
    for (int r = 0; r < 32; r++) rdchk($sformatf("rst_v%0d", r), r, 64'd0);
    wbeat(5'd3, '1, 1'b1, 1'b0);
    rdchk("vl0_write_v3", 3, 64'd0);

    // 2: vsetvl
    vsetvl(7'd20, 8'h01);
    chk("vl_20_m2", 64'(bus.vl), 64'd16);
    chk("avl_20", 64'(bus.avl_reg), 64'd20);
    chk("vtype_01", 64'(bus.vtype), 64'h01);
    vsetvl(7'd5, 8'h18);
    chk("vl_5_e64", 64'(bus.vl), 64'd1);
    chk("vill_ok", 64'(bus.vill), 64'd0);
    vsetvl(7'd7, 8'h04);
    chk("vill_lmul4", 64'(bus.vill), 64'd1);
    chk("vl_ill", 64'(bus.vl), 64'd0);
    chk("vtype_ill", 64'(bus.vtype), 64'h04);
    chk("avl_ill", 64'(bus.avl_reg), 64'd7);
    wbeat(5'd5, '1, 1'b1, 1'b0);
    rdchk("vill_discard_v5", 5, 64'd0);
    chk("vill_no_burst", 64'(bus.busy), 64'd0);
    vsetvl(7'd3, 8'h40);
    chk("vill_rsv", 64'(bus.vill), 64'd1);

    // 3: tail undisturbed
    vsetvl(7'd6, 8'h00);
    chk("vl_6", 64'(bus.vl), 64'd6);
    wbeat(5'd2, '1, 1'b1, 1'b1);
    wbeat(5'd2, 64'd0, 1'b1, 1'b0);
    rdchk("tail_v2", 2, 64'hFFFF_0000_0000_0000);

    // 4: masked LMUL=2 burst
    wbeat(5'd0, 64'h0155, 1'b1, 1'b1);
    wbeat(5'd4, {8{8'hAA}}, 1'b1, 1'b1);
    wbeat(5'd5, {8{8'hAA}}, 1'b1, 1'b1);
    vsetvl(7'd10, 8'h01);
    chk("vl_10", 64'(bus.vl), 64'd10);
    bus.w_valid = 1'b1;
    bus.w_addr  = 5'd4;
    bus.w_data  = 64'h8877_6655_4433_2211;
    bus.w_vm    = 1'b0;
    cycle();
    chk("burst_busy", 64'(bus.busy), 64'd1);
    chk("burst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    bus.w_addr = 5'd0;
    bus.w_data = 64'h0102_0304_0506_0708;
    cycle();
    bus.w_valid = 1'b0;
    bus.w_vm    = 1'b1;
    chk("burst_done_busy", 64'(bus.busy), 64'd0);
    chk("burst_done_ready", 64'(bus.cfg_ready), 64'd1);
    rdchk("mask_v4", 4, 64'hAA77_AA55_AA33_AA11);
    rdchk("mask_v5", 5, 64'hAAAA_AAAA_AAAA_AA08);
    rdchk("mask_v0", 0, 64'h0155);

    // 5: misaligned base, then cfg stalled behind a burst
    vsetvl(7'd32, 8'h02);
    chk("vl_32", 64'(bus.vl), 64'd32);
    wbeat(5'd6, '1, 1'b1, 1'b0);
    chk("werr_pulse", 64'(bus.w_err), 64'd1);
    chk("werr_busy", 64'(bus.busy), 64'd0);
    cycle();
    chk("werr_clear", 64'(bus.w_err), 64'd0);
    rdchk("werr_v6", 6, 64'd0);
    rdchk("werr_v7", 7, 64'd0);
    bus.w_valid = 1'b1;
    bus.w_vm    = 1'b1;
    bus.w_addr  = 5'd8;
    bus.w_data  = {8{8'h11}};
    cycle();
    bus.cfg_valid = 1'b1;
    bus.avl_in    = 7'd3;
    bus.vtype_in  = 8'h00;
    bus.w_data    = {8{8'h22}};
    cycle();
    chk("stall_vl_b1", 64'(bus.vl), 64'd32);
    bus.w_data = {8{8'h33}};
    cycle();
    bus.w_data = {8{8'h44}};
    cycle();
    bus.w_valid = 1'b0;
    chk("stall_vl_b3", 64'(bus.vl), 64'd32);
    chk("stall_idle", 64'(bus.cfg_ready), 64'd1);
    cycle();
    bus.cfg_valid = 1'b0;
    chk("stall_applied_vl", 64'(bus.vl), 64'd3);
    chk("stall_applied_avl", 64'(bus.avl_reg), 64'd3);
    rdchk("grp_v8", 8, {8{8'h11}});
    rdchk("grp_v9", 9, {8{8'h22}});
    rdchk("grp_v10", 10, {8{8'h33}});
    rdchk("grp_v11", 11, {8{8'h44}});
    // CSR update and write in the same cycle: write sees old vl=3
    bus.cfg_valid = 1'b1;
    bus.avl_in    = 7'd0;
    bus.vtype_in  = 8'h00;
    wbeat(5'd12, '1, 1'b1, 1'b0);
    bus.cfg_valid = 1'b0;
    rdchk("old_vl_v12", 12, 64'h0000_0000_00FF_FFFF);
    chk("new_vl_0", 64'(bus.vl), 64'd0);

    // 6: reset mid-burst
    vsetvl(7'd64, 8'h03);
    chk("vl_64", 64'(bus.vl), 64'd64);
    bus.w_valid = 1'b1;
    bus.w_addr  = 5'd16;
    bus.w_data  = '1;
    cycle();
    chk("m8_busy", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    cycle();
    rst         = 1'b1;
    bus.w_valid = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_vl", 64'(bus.vl), 64'd0);
    chk("abort_vtype", 64'(bus.vtype), 64'd0);
    rdchk("abort_v16", 16, 64'd0);
    rdchk("abort_v17", 17, 64'd0);
    rdchk("abort_v4", 4, 64'd0);
    rdchk("abort_v0", 0, 64'd0);

    bus.ra[4:0] = 5'd1;
    bus.w_valid = 1'b1;
    bus.w_whole = 1'b1;
    bus.w_addr  = 5'd1;
    bus.w_data  = 64'hDEAD_BEEF_0123_4567;
    #1;
`ifdef VRF_BYPASS_EN
    chk("bypass_same_cycle", bus.rd[63:0], 64'hDEAD_BEEF_0123_4567);
`else
    chk("nobypass_same_cycle", bus.rd[63:0], 64'd0);
`endif
    cycle();
    bus.w_valid = 1'b0;
    bus.w_whole = 1'b0;
    #1;
    chk("v1_next_cycle", bus.rd[63:0], 64'hDEAD_BEEF_0123_4567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
